// File: rtl/ifetch_q.sv
// ifetch_q: in-order instruction fetch feeding a DEPTH-entry FIFO, with epoch-based flush on redirect.
// Build macro IFETCH_PERF_EN adds the perf_fetched / perf_flushes event counters.
module ifetch_q #(
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-3:0] imem_addr,
   input  logic [31:0]       imem_rdata,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst,
   output logic [ADDR_W-1:0] inst_pc
`ifdef IFETCH_PERF_EN
   ,output logic [31:0]      perf_fetched
   ,output logic [31:0]      perf_flushes
`endif
);

   localparam int               PTR_W = $clog2(DEPTH);
   localparam int               CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(DEPTH);

   // Handshakes: inst_valid/inst_ready is strict valid/ready -- the head is popped on a
   // cycle with both high, and inst/inst_pc stay stable while inst_valid && !inst_ready.
   // imem_req has no back-pressure; the memory answers exactly one cycle later.

   logic [ADDR_W-1:0] fpc;
   logic [ADDR_W-1:0] fetch_pc;
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [CNT_W-1:0]  occupancy;
   logic              epoch;
   logic              inflight;
   logic              inflight_epoch;
   logic [ADDR_W-1:0] inflight_pc;
   logic              resp_wr;
   logic              pop;

   logic [31:0]       q_inst [DEPTH];
   logic [ADDR_W-1:0] q_pc   [DEPTH];

   always_comb begin
      fetch_pc   = redirect_valid ? (redirect_pc & ~ADDR_W'(3)) : fpc;
      // Credit: queued entries plus the one response that may still land must fit.
      occupancy  = count + CNT_W'(inflight);
      imem_req   = rst && (redirect_valid || (occupancy < FULL));
      imem_addr  = fetch_pc[ADDR_W-1:2];
      resp_wr    = inflight && (inflight_epoch == epoch) && !redirect_valid;
      inst_valid = (count != '0);
      pop        = inst_valid && inst_ready && !redirect_valid;
      inst       = inst_valid ? q_inst[rd_ptr] : '0;
      inst_pc    = inst_valid ? q_pc[rd_ptr]   : '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         fpc            <= RESET_PC;
         epoch          <= 1'b0;
         inflight       <= 1'b0;
         inflight_epoch <= 1'b0;
         inflight_pc    <= '0;
         count          <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
      end else if (redirect_valid) begin
         // Flush wins over any pop or response in the same cycle.
         fpc            <= fetch_pc + ADDR_W'(4);
         epoch          <= ~epoch;
         inflight       <= 1'b1;
         inflight_epoch <= ~epoch;
         inflight_pc    <= fetch_pc;
         count          <= '0;
         wr_ptr         <= '0;
         rd_ptr         <= '0;
      end else begin
         inflight <= imem_req;
         if (imem_req) begin
            fpc            <= fpc + ADDR_W'(4);
            inflight_pc    <= fpc;
            inflight_epoch <= epoch;
         end
         if (resp_wr) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
         case ({resp_wr, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is never read while its count slot is empty, so it needs no reset.
   always_ff @(posedge clk) begin
      if (resp_wr) begin
         q_inst[wr_ptr] <= imem_rdata;
         q_pc[wr_ptr]   <= inflight_pc;
      end
   end

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetched <= '0;
         perf_flushes <= '0;
      end else begin
         if (resp_wr)        perf_fetched <= perf_fetched + 32'd1;
         if (redirect_valid) perf_flushes <= perf_flushes + 32'd1;
      end
   end
`endif

   no_overflow: assert property (@(posedge clk) disable iff (!rst)
      !(resp_wr && !pop && (count == FULL)));

endmodule

// File: tb/tb_ifetch_q.sv
// Bench for ifetch_q: directed boot/stall/reset/redirect/wrap scenarios plus a random phase,
// all pops checked against an expected-PC scoreboard.
module tb_ifetch_q;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [29:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   logic        redirect8;
   logic [7:0]  redirect_pc8;
   logic        req8;
   logic [5:0]  addr8;
   logic [31:0] rdata8;
   logic        valid8;
   logic        ready8;
   logic [31:0] inst8;
   logic [7:0]  inst_pc8;

`ifdef IFETCH_PERF_EN
   logic [31:0] perf_fetched, perf_flushes, perf_fetched8, perf_flushes8;
   int          fetched_m, flush_m;
   logic        prev_req;
`endif

   int          n_vec = 0;
   int          n_err = 0;
   int          req_cnt = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp_tail;
   logic [31:0] sb_e;
   logic        prev_redir = 1'b0;
   logic        prev_hold = 1'b0;
   logic [31:0] hold_pc, hold_inst;

   ifetch_q #(.ADDR_W(32), .DEPTH(4)) u_dut (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
      .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc)
`ifdef IFETCH_PERF_EN
      , .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
`endif
   );

   ifetch_q #(.ADDR_W(8), .DEPTH(2)) u_dut8 (
      .clk(clk), .rst(rst),
      .redirect_valid(redirect8), .redirect_pc(redirect_pc8),
      .imem_req(req8), .imem_addr(addr8), .imem_rdata(rdata8),
      .inst_valid(valid8), .inst_ready(ready8), .inst(inst8), .inst_pc(inst_pc8)
`ifdef IFETCH_PERF_EN
      , .perf_fetched(perf_fetched8), .perf_flushes(perf_flushes8)
`endif
   );

   // ---------------- clock / reset / memory ----------------
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got %0d vectors, expected completion", n_vec);
      $fatal(1);
   end

   function automatic logic [31:0] mem_fn(input logic [31:0] pc);
      return (pc * 32'd3) ^ 32'h5EED_0000;
   endfunction

   always @(posedge clk) begin
      imem_rdata <= imem_req ? mem_fn({imem_addr, 2'b00}) : 32'hDEAD_BEEF;
      rdata8     <= req8 ? mem_fn({24'h0, addr8, 2'b00}) : 32'hDEAD_BEEF;
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic sb_reset(input logic [31:0] pc);
      exp_q.delete();
      exp_tail = pc - 32'd4;
      repeat (8) begin
         exp_tail = exp_tail + 32'd4;
         exp_q.push_back(exp_tail);
      end
   endtask

   // Monitor sampled at negedge, between TB input changes (posedge+1) and the next edge.
   always @(negedge clk) begin
      if (rst) begin
         if (imem_req) req_cnt++;
         if (prev_redir) chk("flush_valid", 32'(inst_valid), 32'd0);
         if (!inst_valid) begin
            chk("idle_inst", inst, 32'd0);
            chk("idle_pc", inst_pc, 32'd0);
         end
         if (prev_hold) begin
            chk("hold_pc", inst_pc, hold_pc);
            chk("hold_inst", inst, hold_inst);
         end
         if (inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) chk("sb_empty", 32'(exp_q.size()), 32'd1);
            else begin
               sb_e = exp_q.pop_front();
               exp_tail = exp_tail + 32'd4;
               exp_q.push_back(exp_tail);
               chk("sb_pc", inst_pc, sb_e);
               chk("sb_inst", inst, mem_fn(sb_e));
            end
         end
`ifdef IFETCH_PERF_EN
         if (redirect_valid) flush_m++;
         if (prev_req && !redirect_valid) fetched_m++;
         prev_req = imem_req;
`endif
         prev_redir = redirect_valid;
         prev_hold  = inst_valid && !inst_ready && !redirect_valid;
         hold_pc    = inst_pc;
         hold_inst  = inst;
      end else begin
         prev_redir = 1'b0;
         prev_hold  = 1'b0;
`ifdef IFETCH_PERF_EN
         prev_req  = 1'b0;
         fetched_m = 0;
         flush_m   = 0;
`endif
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic redirect(input logic [31:0] pc);
      redirect_valid = 1'b1;
      redirect_pc    = pc;
      sb_reset(pc & ~32'd3);
      #1;
      chk("redir_req", 32'(imem_req), 32'd1);
      chk("redir_addr", 32'(imem_addr), 32'(pc[31:2]));
      tick();
      redirect_valid = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   logic [7:0] e8 [3];
   int         n8;

   initial begin
      rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; inst_ready = 1'b1;
      redirect8 = 1'b0; redirect_pc8 = '0; ready8 = 1'b1;
      e8[0] = 8'hFC; e8[1] = 8'h00; e8[2] = 8'h04;
      sb_reset(32'h0);
      repeat (3) tick();
      #1;
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_valid", 32'(inst_valid), 32'd0);
      chk("rst_inst", inst, 32'd0);
      chk("rst_pc", inst_pc, 32'd0);

      // Boot stream: addresses 0,1,2..., first instruction two cycles after the first request.
      rst = 1'b1;
      sb_reset(32'h0);
      #1;
      chk("boot_req", 32'(imem_req), 32'd1);
      chk("boot_addr", 32'(imem_addr), 32'd0);
      for (int k = 1; k <= 4; k++) begin
         tick(); #1;
         chk("boot_addr", 32'(imem_addr), 32'(k));
         chk("boot_valid", 32'(inst_valid), (k >= 2) ? 32'd1 : 32'd0);
         if (k >= 2) chk("boot_pc", inst_pc, 32'((k - 2) * 4));
      end

      // Stall until the queue is full and fetch stops.
      tick(); inst_ready = 1'b0;
      repeat (10) tick();
      #1;
      chk("stall_req", 32'(imem_req), 32'd0);
      chk("stall_valid", 32'(inst_valid), 32'd1);

      // Reset with a full queue, then a stalled restart: exactly DEPTH requests.
      tick(); rst = 1'b0;
      #1;
      chk("mrst_valid", 32'(inst_valid), 32'd0);
      chk("mrst_inst", inst, 32'd0);
      chk("mrst_req", 32'(imem_req), 32'd0);
      sb_reset(32'h0);
      tick(); tick();
      rst = 1'b1; req_cnt = 0;
      repeat (10) tick();
      #1;
      chk("bp_reqs", 32'(req_cnt), 32'd4);
      chk("bp_req_low", 32'(imem_req), 32'd0);
      chk("bp_head", inst_pc, 32'h0);
      tick(); inst_ready = 1'b1;
      repeat (8) tick();

      // Redirect with a response in flight; target bits [1:0] ignored.
      redirect(32'h103);
      #1;
      chk("rd_drop", 32'(inst_valid), 32'd0);
      tick(); #1;
      chk("rd_valid", 32'(inst_valid), 32'd1);
      chk("rd_pc0", inst_pc, 32'h100);
      chk("rd_inst0", inst, mem_fn(32'h100));
      tick(); #1;
      chk("rd_pc1", inst_pc, 32'h104);

      // Redirect while the queue is full and stalled.
      tick(); inst_ready = 1'b0;
      repeat (6) tick();
      redirect(32'h2000);
      #1;
      chk("rd_full_drop", 32'(inst_valid), 32'd0);
      repeat (3) tick();
      inst_ready = 1'b1;
      repeat (6) tick();

      // Random back-pressure and redirects.
      for (int i = 0; i < 400; i++) begin
         inst_ready = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 24) == 0) redirect($urandom);
         else tick();
      end
      inst_ready = 1'b1;
      repeat (6) tick();

      // 8-bit PC wrap on the ADDR_W=8, DEPTH=2 instance.
      redirect8 = 1'b1; redirect_pc8 = 8'hFC;
      #1;
      chk("a8_req", 32'(req8), 32'd1);
      chk("a8_addr", 32'(addr8), 32'h3F);
      tick();
      redirect8 = 1'b0;
      #1;
      chk("a8_wrap", 32'(addr8), 32'h0);
      n8 = 0;
      for (int c = 0; c < 10 && n8 < 3; c++) begin
         if (valid8) begin
            chk("a8_pc", 32'(inst_pc8), 32'(e8[n8]));
            chk("a8_inst", inst8, mem_fn({24'h0, e8[n8]}));
            n8++;
         end
         tick(); #1;
      end
      if (n8 != 3) chk("a8_timeout", 32'(n8), 32'd3);

`ifdef IFETCH_PERF_EN
      tick(); #1;
      chk("perf_flushes", perf_flushes, 32'(flush_m));
      chk("perf_fetched", perf_fetched, 32'(fetched_m));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/ifetch_q.md
IFETCH_Q -- requirements
Module: ifetch_q

Interface
REQ-001 Parameter ADDR_W, default 32: PC / instruction-address width in bits; legal range 8..32.
REQ-002 Parameter DEPTH, default 4: fetch-queue entries; power of two; legal range 2..16.
REQ-003 Parameter RESET_PC, default 0: first fetch address after reset; bits [1:0] SHALL be 0.
REQ-004 One clock and one reset: clk is the single clock; reset is rst, asynchronous, active-low.
REQ-005 Port clk  input  1: all state updates on the rising edge.
REQ-006 Port rst  input  1: asynchronous, active-low reset.
REQ-007 Port redirect_valid  input  1: taken branch/jump; flush and restart fetch.
REQ-008 Port redirect_pc  input  ADDR_W: redirect target; bits [1:0] ignored and forced to 0.
REQ-009 Port imem_req  output  1: instruction-memory read strobe this cycle.
REQ-010 Port imem_addr  output  ADDR_W-2: word address, i.e. fetch PC[ADDR_W-1:2].
REQ-011 Port imem_rdata  input  32: read data, valid exactly 1 cycle after imem_req.
REQ-012 Port inst_valid  output  1: queue head holds a valid instruction.
REQ-013 Port inst_ready  input  1: decode accepts head; pop when inst_valid && inst_ready.
REQ-014 Port inst  output  32: head instruction; 32'h0 whenever inst_valid=0.
REQ-015 Port inst_pc  output  ADDR_W: PC of head instruction; 0 whenever inst_valid=0.

Function
REQ-016 Fetch PC register fpc; imem_addr = fpc[ADDR_W-1:2] except in a redirect cycle (REQ-021).
REQ-017 imem_req=1 iff count + inflight < DEPTH, or redirect_valid=1; inflight is 1 if imem_req was high last cycle and not squashed.
REQ-018 On an issued request fpc advances by 4, modulo 2^ADDR_W (fpc = 2^ADDR_W-4 wraps to 0).
REQ-019 A response is written at the queue tail on the edge ending the cycle after its request, tagged with its PC; no bypass, so the earliest inst_valid is 2 cycles after the request.
REQ-020 Queue is FIFO, DEPTH entries; the credit rule in REQ-017 guarantees no overflow; a write to a full queue is a design error flagged by an assertion.
REQ-021 redirect_valid=1: queue cleared; any in-flight response discarded (epoch bit toggles, mismatched responses dropped); imem_addr = redirect_pc[ADDR_W-1:2] with imem_req=1 in the same cycle; fpc <- redirect_pc+4.
REQ-022 Redirect has priority over a simultaneous pop and a simultaneous response write; neither takes effect.
REQ-023 Simultaneous pop and response write on a full queue is legal; count unchanged.
REQ-024 inst_valid SHALL drop in the cycle after redirect_valid and reassert no earlier than 2 cycles after it.
REQ-025 inst, inst_pc and inst_valid are registered outputs of the queue head; no combinational path from inst_ready to them.
REQ-026 inst_ready=0 holds the head stable (inst and inst_pc unchanged) until it is popped or flushed.

Reset
REQ-027 While rst=0: fpc=RESET_PC, queue empty, inflight=0, epoch=0, imem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-028 Reset asserted mid-operation discards all queued and in-flight data immediately; the first request after release is RESET_PC on the first rising edge with rst=1.

Configuration
REQ-029 Macro IFETCH_PERF_EN defined: adds outputs perf_fetched[31:0] (count of queue writes) and perf_flushes[31:0] (count of redirect cycles); both wrap modulo 2^32 and reset to 0.
REQ-030 Macro IFETCH_PERF_EN undefined: those ports and counters are absent; all other behaviour is identical.

Verification
REQ-031 Reset release, inst_ready=1, memory returns addr*4 -> imem_addr sequence 0,1,2...; inst_pc 0,4,8 back-to-back from cycle 2, one instruction per cycle.
REQ-032 inst_ready=0 for 10 cycles with DEPTH=4 -> exactly 4 requests issued, imem_req low afterwards, no data lost; on release the 4 entries drain in order.
REQ-033 redirect_valid pulse, redirect_pc=0x103 with a response in flight -> stale response dropped; next inst_pc=0x100 appears 2 cycles later, then 0x104.
REQ-034 ADDR_W=8, redirect_pc=0xFC -> inst_pc sequence 0xFC, 0x00, 0x04.
REQ-035 rst asserted mid-stream with a full queue -> inst_valid=0 and inst=0 immediately; after release the first inst_pc is RESET_PC.
REQ-036 With IFETCH_PERF_EN defined, 20 fetches and 3 redirects -> perf_fetched matches the number of queue writes and perf_flushes=3.
